// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enabled register write port among NREQ requesters.
// One registered grant per cycle; the winner's data drives the shared en/d pair for one cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | en=0, gnt=0; shared register holds its value
// ST_GRANT | en=1, gnt one-hot; d carries the winner's data, ack to winner
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    input  logic                  hold,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  en,
    output logic [WIDTH-1:0]      d,
    output logic                  busy
);

    localparam int PTRW = $clog2(NREQ);
    localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [PTRW-1:0]   r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [WIDTH-1:0]  r_d;

    logic [NREQ-1:0]   w_elig;
    logic [NREQ-1:0]   w_onehot;
    logic              w_found;
    logic [PTRW-1:0]   w_cand;
    logic [PTRW-1:0]   w_win;
    logic [PTRW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0]  w_data;

    // The current winner still holds req during its ack cycle, so mask it out.
    assign w_elig = req & ~r_gnt;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
            w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + 1'b1;
        end
    end

    always_comb begin
        w_onehot = '0;
        w_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_found && (w_win == PTRW'(i))) begin
                w_onehot[i] = 1'b1;
                w_data      = data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Explicit wrap so non-power-of-2 NREQ never lands on an unused index.
    assign w_ptr_nxt = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_d     <= '0;
            r_ptr   <= '0;
        end else if (!hold && w_found) begin
            r_state <= ST_GRANT;
            r_gnt   <= w_onehot;
            r_d     <= w_data;
            r_ptr   <= w_ptr_nxt;
        end else begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
        end
    end

    assign en   = (r_state == ST_GRANT);
    assign gnt  = r_gnt;
    assign ack  = r_gnt & {NREQ{en}};
    assign d    = r_d;
    assign busy = |req;

endmodule
